ttc3_cmd_host: RTL

TTC3_CMD_HOST -- requirements
Module: ttc3_cmd_host

---
 rtl/ttc3_cmd_host.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ttc3_cmd_host.sv
// rtl/ttc3_cmd_host.sv - host byte-stream to root-of-trust command bridge (optional timeout: TTC3_CMD_TIMEOUT_EN)
module ttc3_cmd_host #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         cmd_valid,
  output logic [2:0]   cmd_op,
  output logic [511:0] cmd_data,
  input  logic         cmd_ready,
  input  logic         cmd_done,
  input  logic         resp_valid,
  input  logic [511:0] resp_data,
  output logic         busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_SEND_STAT = 3'd4;
  localparam logic [2:0] S_SEND_DATA = 3'd5;

  logic [2:0]   r_state;
  logic [5:0]   r_cnt;
  logic [5:0]   r_plast;
  logic [5:0]   r_rlen;
  logic [2:0]   r_cmd_op;
  logic [511:0] r_cmd_data;
  logic [511:0] r_resp;
  logic [7:0]   r_out_data;

  logic         w_in_acc;
  logic         w_out_acc;
  logic [5:0]   w_cnt_inc;
  logic [2:0]   w_hdr_op;

  // cmd_done carries no control meaning here; the response pulse alone drives capture
  logic w_unused_done;
  assign w_unused_done = cmd_done;

  // Last payload byte index per opcode (only meaningful when the opcode has a payload)
  function automatic logic [5:0] f_plast(input logic [2:0] op);
    case (op)
      3'b010:  f_plast = 6'd63;
      3'b011:  f_plast = 6'd31;
      3'b100:  f_plast = 6'd31;
      default: f_plast = 6'd0;
    endcase
  endfunction

  function automatic logic f_has_pay(input logic [2:0] op);
    f_has_pay = (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
  endfunction

  // Response byte count per opcode
  function automatic logic [5:0] f_rlen(input logic [2:0] op);
    case (op)
      3'b001:  f_rlen = 6'd16;
      3'b010:  f_rlen = 6'd32;
      3'b011:  f_rlen = 6'd32;
      3'b100:  f_rlen = 6'd16;
      3'b101:  f_rlen = 6'd32;
      default: f_rlen = 6'd0;
    endcase
  endfunction

  // Gated by reset so the host sees in_ready low for the whole reset window
  assign in_ready  = ~reset & ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign out_valid = (r_state == S_SEND_STAT) || (r_state == S_SEND_DATA);
  assign cmd_valid = (r_state == S_ISSUE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign cmd_op    = r_cmd_op;
  assign cmd_data  = r_cmd_data;

  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = out_valid & out_ready;
  assign w_cnt_inc = r_cnt + 6'd1;
  assign w_hdr_op  = in_data[2:0];

`ifdef TTC3_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // Cycles spent in WAIT_RESP; cleared whenever the bridge is elsewhere
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_tmo <= '0;
    else if (r_state == S_WAIT_RESP && !resp_valid)
      r_tmo <= r_tmo + 1'b1;
    else
      r_tmo <= '0;
  end

  logic w_tmo_hit;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
`endif

  // Frame sequencing: header decode, payload load, command handshake, response streaming
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 6'd0;
      r_plast    <= 6'd0;
      r_rlen     <= 6'd0;
      r_cmd_op   <= 3'd0;
      r_cmd_data <= '0;
      r_resp     <= '0;
      r_out_data <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_acc) begin
            case (w_hdr_op)
              3'b000: begin
                r_state <= S_IDLE;
              end
              3'b110, 3'b111: begin
                r_rlen     <= 6'd0;
                r_out_data <= 8'h01;
                r_state    <= S_SEND_STAT;
              end
              default: begin
                r_cmd_data <= '0;
                r_cmd_op   <= w_hdr_op;
                r_plast    <= f_plast(w_hdr_op);
                r_rlen     <= f_rlen(w_hdr_op);
                r_cnt      <= 6'd0;
                r_state    <= f_has_pay(w_hdr_op) ? S_LOAD : S_ISSUE;
              end
            endcase
          end
        end
        S_LOAD: begin
          if (w_in_acc) begin
            r_cmd_data[{r_cnt, 3'b000} +: 8] <= in_data;
            if (r_cnt == r_plast) begin
              r_cnt   <= 6'd0;
              r_state <= S_ISSUE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready)
            r_state <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (resp_valid) begin
            r_resp     <= resp_data;
            r_out_data <= 8'h00;
            r_state    <= S_SEND_STAT;
          end
`ifdef TTC3_CMD_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_rlen     <= 6'd0;
            r_out_data <= 8'hEE;
            r_state    <= S_SEND_STAT;
          end
`endif
        end
        S_SEND_STAT: begin
          if (w_out_acc) begin
            if (r_rlen != 6'd0) begin
              r_cnt      <= 6'd0;
              r_out_data <= r_resp[7:0];
              r_state    <= S_SEND_DATA;
            end else begin
              r_out_data <= 8'h00;
              r_resp     <= '0;
              r_state    <= S_IDLE;
            end
          end
        end
        S_SEND_DATA: begin
          if (w_out_acc) begin
            if (r_cnt == r_rlen - 6'd1) begin
              r_cnt      <= 6'd0;
              r_out_data <= 8'h00;
              r_resp     <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_cnt      <= w_cnt_inc;
              r_out_data <= r_resp[{w_cnt_inc, 3'b000} +: 8];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
